// File: rtl/fifo_pkg.sv
// Shared definitions for the watermark FIFO: pointer sizing and
// configuration legality checks evaluated at elaboration time.
package fifo_pkg;

    // Address width for a given depth; a depth of 1 still gets one address bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    // Legal configuration: power-of-two depth >= 2, nonzero width, and both
    // watermarks inside the range the occupancy count can actually reach.
    function automatic bit fifo_cfg_ok(input int width, input int depth,
                                       input int afull, input int aempty);
        return (width >= 1) && is_pow2(depth)
            && (afull >= 1) && (afull <= depth)
            && (aempty >= 0) && (aempty <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_wm_if.sv
// Bus bundle between a FIFO producer/consumer (master) and fifo_wm (slave).
//
// Handshake: write and read are requests sampled on the rising clock edge.
// A write is taken when the FIFO is not full, or when it is full and a read
// is taken in the same cycle; a read is taken when the FIFO is not empty.
// full/empty therefore act as the registered "not ready" indications, and a
// request that is not taken is dropped and recorded in overflow/underflow.
interface fifo_wm_if
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = ptr_width(FIFO_DEPTH) + 1;

    logic [FIFO_WIDTH-1:0] wrdata;
    logic                  write;
    logic                  read;
    logic                  clr_err;
    logic [FIFO_WIDTH-1:0] rddata;
    logic                  rdvalid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wrdata, write, read, clr_err,
        input  rddata, rdvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wrdata, write, read, clr_err,
        output rddata, rdvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_wm_ctrl.sv
// Pointer, occupancy and flag control for fifo_wm. All status outputs are
// registered from the next-state count, so request inputs never reach a flag
// combinationally.
module fifo_wm_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2,
    localparam int PW = ptr_width(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          write,
    input  logic          read,
    input  logic          clr_err,
    output logic          wr_ok,
    output logic          rd_ok,
    output logic [PW-1:0] wr_addr,
    output logic [PW-1:0] rd_addr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);
    // Pointers carry one extra wrap bit and roll over modulo 2*FIFO_DEPTH.
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          full_q;
    logic          empty_q;
    logic          afull_q;
    logic          aempty_q;
    logic          ovf_q;
    logic          unf_q;

    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign rd_ok = read & ~empty_q;
    assign wr_ok = write & (~full_q | rd_ok);

    // Occupancy after this cycle's accepted operations.
    always_comb begin
        count_nxt = count_q;
        if (wr_ok && !rd_ok) begin
            count_nxt = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + (PW + 1)'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + (PW + 1)'(1);
            end
            count_q <= count_nxt;
        end
    end

    // Status flags, registered from the next occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            full_q   <= (count_nxt == CW'(FIFO_DEPTH));
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= CW'(AFULL_THRESH));
            aempty_q <= (count_nxt <= CW'(AEMPTY_THRESH));
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (write & ~wr_ok) | (ovf_q & ~clr_err);
            unf_q <= (read & ~rd_ok) | (unf_q & ~clr_err);
        end
    end

    assign wr_addr      = wr_ptr[PW-1:0];
    assign rd_addr      = rd_ptr[PW-1:0];
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: rtl/fifo_wm.sv
// Single-clock FIFO with watermarks, occupancy count, sticky error flags and
// a selectable read path (show-ahead or registered). Storage and read data
// live here; pointers and flags live in fifo_wm_ctrl.
module fifo_wm
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2,
    parameter int RD_REG        = 0
) (
    input logic      clk,
    input logic      reset,
    fifo_wm_if.slave bus
);
    localparam int  PW     = ptr_width(FIFO_DEPTH);
    localparam int  CW     = PW + 1;
    localparam bit  CFG_OK = fifo_cfg_ok(FIFO_WIDTH, FIFO_DEPTH,
                                         AFULL_THRESH, AEMPTY_THRESH);

    if (!CFG_OK) begin : g_cfg_err
        $error("fifo_wm: illegal depth or watermark configuration");
    end

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  wr_ok;
    logic                  rd_ok;
    logic [PW-1:0]         wr_addr;
    logic [PW-1:0]         rd_addr;
    logic                  empty;
    logic [FIFO_WIDTH-1:0] rd_q;
    logic                  rdv_q;

    fifo_wm_ctrl #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .AFULL_THRESH  (AFULL_THRESH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .write        (bus.write),
        .read         (bus.read),
        .clr_err      (bus.clr_err),
        .wr_ok        (wr_ok),
        .rd_ok        (rd_ok),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .count        (bus.count),
        .full         (bus.full),
        .empty        (empty),
        .almost_full  (bus.almost_full),
        .almost_empty (bus.almost_empty),
        .overflow     (bus.overflow),
        .underflow    (bus.underflow)
    );

    // Storage array; cleared on reset so the show-ahead output reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= bus.wrdata;
        end
    end

    // Registered read stage; only drives the outputs when RD_REG is set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            rdv_q <= 1'b0;
        end else begin
            rdv_q <= rd_ok;
            if (rd_ok) begin
                rd_q <= mem[rd_addr];
            end
        end
    end

    assign bus.empty   = empty;
    assign bus.rddata  = (RD_REG != 0) ? rd_q : mem[rd_addr];
    assign bus.rdvalid = (RD_REG != 0) ? rdv_q : ~empty;

    logic unused_cw;
    assign unused_cw = (CW == 0);

endmodule
